// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller:
//   - IMEM_SIZE_DEF  : instruction memory depth in words, shared with the
//                      memory side so both agree on the legal address range
//   - RESET_PC_DEF   : default word address fetched first after reset
//   - EXC_VECTOR_DEF : default word address entered on an exception
//   - fetch_state_t  : controller FSM state encoding
//   - pc_legal()     : true when a word address lies inside instruction memory
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package fetch_ctrl_pkg;

    localparam int unsigned IMEM_SIZE_DEF  = 1024;
    localparam logic [31:0] RESET_PC_DEF   = 32'd0;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'd16;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    // Word address is fetchable only if it falls inside the memory.
    function automatic logic pc_legal(input logic [31:0] pc, input int unsigned size);
        return (pc < size);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational target selection for the fetch controller. Picks the word
// address the controller should present next cycle and classifies it.
//
// Priority: exc > br_taken > jmp > stall > sequential.
//
// Parameters:
//   IMEM_SIZE   instruction memory depth in words
//   EXC_VECTOR  word address loaded on an exception
// Ports:
//   cur_pc        in  32  address currently on newPC
//   advance       in  1   current address was a live fetch, so sequential
//                         flow moves to cur_pc+1 (otherwise it re-fetches)
//   stall         in  1   hold current address
//   exc           in  1   exception request (tied low when exceptions are off)
//   br_taken      in  1   branch resolved taken
//   br_target     in  32  branch word address
//   jmp           in  1   jump request
//   jmp_target    in  32  jump word address
//   next_pc       out 32  selected next address
//   redirect      out 1   next_pc comes from exc/branch/jump
//   hold          out 1   stall with no redirect: address is kept
//   out_of_range  out 1   next_pc lies outside instruction memory
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_next_pc
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_SIZE  = IMEM_SIZE_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] cur_pc,
    input  logic        advance,
    input  logic        stall,
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        hold,
    output logic        out_of_range
);

    always_comb begin
        next_pc  = cur_pc;
        redirect = 1'b0;
        hold     = 1'b0;
        if (exc) begin
            next_pc  = EXC_VECTOR;
            redirect = 1'b1;
        end else if (br_taken) begin
            // A branch wins over a jump issued in the same cycle.
            next_pc  = br_target;
            redirect = 1'b1;
        end else if (jmp) begin
            next_pc  = jmp_target;
            redirect = 1'b1;
        end else if (stall) begin
            hold     = 1'b1;
        end else if (advance) begin
            // Word addressing: wraps naturally modulo 2^32.
            next_pc  = cur_pc + 32'd1;
        end
    end

    assign out_of_range = !pc_legal(next_pc, IMEM_SIZE);

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller. Generates the word address for the fetch
// stage, handles stalls, branch/jump redirects (with a one-cycle flush of the
// instruction already in flight) and halts when the program runs off the end
// of instruction memory. All outputs are registered, so a redirect presented
// in cycle N shows up on newPC in cycle N+1.
//
// Optional feature, macro FETCH_CTRL_EXC_EN:
//   adds port exc (highest-priority redirect to EXC_VECTOR) and port epc,
//   which captures the address that was on newPC when the exception was taken.
//   Without the macro those ports do not exist and EXC_VECTOR has no effect.
//
// Parameters:
//   RESET_PC    first word address fetched after reset
//   IMEM_SIZE   instruction memory depth in words
//   EXC_VECTOR  exception entry word address
// Ports:
//   CLK          in  1   clock, rising edge
//   RST          in  1   synchronous active-high reset
//   stall        in  1   hold current PC, no new fetch
//   br_taken     in  1   branch resolved taken this cycle
//   br_target    in  32  branch word address
//   jmp          in  1   jump request this cycle
//   jmp_target   in  32  jump word address
//   exc          in  1   exception request       (FETCH_CTRL_EXC_EN only)
//   epc          out 32  faulting fetch address  (FETCH_CTRL_EXC_EN only)
//   newPC        out 32  word address driven to the fetch stage
//   fetch_valid  out 1   newPC is a live fetch this cycle
//   flush        out 1   kill the instruction held by the fetch stage
//   halted       out 1   controller is in HALT
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned IMEM_SIZE  = IMEM_SIZE_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
`ifdef FETCH_CTRL_EXC_EN
    input  logic        exc,
    output logic [31:0] epc,
`endif
    output logic [31:0] newPC,
    output logic        fetch_valid,
    output logic        flush,
    output logic        halted
);

    // A RESET_PC outside memory means there is nothing legal to fetch at all.
    localparam logic BOOT_LEGAL = pc_legal(RESET_PC, IMEM_SIZE);

    fetch_state_t state;

    logic        exc_req;
    logic        advance;
    logic [31:0] next_pc;
    logic        redirect;
    logic        hold;
    logic        out_of_range;

`ifdef FETCH_CTRL_EXC_EN
    assign exc_req = exc;
`else
    assign exc_req = 1'b0;
`endif

    // Leaving STALL re-fetches the held address; from RUN/FLUSH the address
    // just fetched was live, so sequential flow moves on by one word.
    assign advance = (state != ST_STALL);

    fetch_next_pc #(
        .IMEM_SIZE  (IMEM_SIZE),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .cur_pc       (newPC),
        .advance      (advance),
        .stall        (stall),
        .exc          (exc_req),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .next_pc      (next_pc),
        .redirect     (redirect),
        .hold         (hold),
        .out_of_range (out_of_range)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_BOOT;
            newPC       <= RESET_PC;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
`ifdef FETCH_CTRL_EXC_EN
            epc         <= 32'd0;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
                    flush <= 1'b0;
                    if (BOOT_LEGAL) begin
                        state       <= ST_RUN;
                        fetch_valid <= 1'b1;
                    end else begin
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end

                // RUN, STALL and FLUSH share one decision tree; only the
                // sequential step differs, which fetch_next_pc handles.
                ST_RUN, ST_STALL, ST_FLUSH: begin
                    if (out_of_range) begin
                        // newPC is left untouched: it keeps the last legal address.
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                        flush       <= 1'b0;
                        halted      <= 1'b1;
                    end else if (redirect) begin
                        state       <= ST_FLUSH;
                        newPC       <= next_pc;
                        fetch_valid <= 1'b1;
                        flush       <= 1'b1;
`ifdef FETCH_CTRL_EXC_EN
                        if (exc) begin
                            epc <= newPC;
                        end
`endif
                    end else if (hold) begin
                        state       <= ST_STALL;
                        fetch_valid <= 1'b0;
                        flush       <= 1'b0;
                    end else begin
                        state       <= ST_RUN;
                        newPC       <= next_pc;
                        fetch_valid <= 1'b1;
                        flush       <= 1'b0;
                    end
                end

                ST_HALT: begin
                    // Only RST leaves HALT.
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                    halted      <= 1'b1;
                end

                default: begin
                    state       <= ST_HALT;
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                    halted      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps

module tb_fetch_ctrl;

    localparam int unsigned SIZE = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] newPC;
    logic        fetch_valid;
    logic        flush;
    logic        halted;

    // Second instance with a 4-word memory for the end-of-memory halt case.
    logic        rst_s;
    logic        s_stall      = 1'b0;
    logic        s_br_taken   = 1'b0;
    logic [31:0] s_br_target  = 32'd0;
    logic        s_jmp        = 1'b0;
    logic [31:0] s_jmp_target = 32'd0;
    logic [31:0] s_pc;
    logic        s_valid;
    logic        s_flush;
    logic        s_halted;

`ifdef FETCH_CTRL_EXC_EN
    logic        exc;
    logic [31:0] epc;
    logic        s_exc = 1'b0;
    logic [31:0] s_epc;
`endif

    int checks = 0;
    int errors = 0;
    logic small_done = 1'b0;

    always #5 CLK = ~CLK;

    fetch_ctrl #(.RESET_PC(32'd0), .IMEM_SIZE(SIZE)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
`ifdef FETCH_CTRL_EXC_EN
        .exc         (exc),
        .epc         (epc),
`endif
        .newPC       (newPC),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .halted      (halted)
    );

    fetch_ctrl #(.RESET_PC(32'd0), .IMEM_SIZE(4)) dut_small (
        .CLK         (CLK),
        .RST         (rst_s),
        .stall       (s_stall),
        .br_taken    (s_br_taken),
        .br_target   (s_br_target),
        .jmp         (s_jmp),
        .jmp_target  (s_jmp_target),
`ifdef FETCH_CTRL_EXC_EN
        .exc         (s_exc),
        .epc         (s_epc),
`endif
        .newPC       (s_pc),
        .fetch_valid (s_valid),
        .flush       (s_flush),
        .halted      (s_halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks the fetch address and whether the last presented address was a
    // live fetch; after a hold the same address is fetched again.
    logic [31:0] m_pc     = 32'd0;
    logic        m_valid  = 1'b0;
    logic        m_flush  = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_boot   = 1'b1;
    logic [31:0] m_epc    = 32'd0;

    task automatic model_halt();
        m_halted = 1'b1;
        m_valid  = 1'b0;
        m_flush  = 1'b0;
    endtask

    task automatic model_step();
        logic        e;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] nxt;
        e = 1'b0;
`ifdef FETCH_CTRL_EXC_EN
        e = exc;
`endif
        if (RST) begin
            m_pc = 32'd0; m_valid = 1'b0; m_flush = 1'b0;
            m_halted = 1'b0; m_boot = 1'b1; m_epc = 32'd0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b1; m_flush = 1'b0;
        end else begin
            redir = e | br_taken | jmp;
            tgt   = e ? 32'd16 : (br_taken ? br_target : jmp_target);
            if (redir) begin
                if (tgt >= SIZE) model_halt();
                else begin
                    if (e) m_epc = m_pc;
                    m_pc = tgt; m_valid = 1'b1; m_flush = 1'b1;
                end
            end else if (stall) begin
                m_valid = 1'b0; m_flush = 1'b0;
            end else begin
                nxt = m_valid ? m_pc + 32'd1 : m_pc;
                if (nxt >= SIZE) model_halt();
                else begin
                    m_pc = nxt; m_valid = 1'b1; m_flush = 1'b0;
                end
            end
        end
    endtask

    always @(posedge CLK) model_step();

    // Compare process: outputs are stable at the falling edge.
    always @(negedge CLK) begin
        check("model_newPC", newPC, m_pc);
        check("model_fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
        check("model_flush", {31'd0, flush}, {31'd0, m_flush});
        check("model_halted", {31'd0, halted}, {31'd0, m_halted});
`ifdef FETCH_CTRL_EXC_EN
        check("model_epc", epc, m_epc);
`endif
    end

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- small-memory instance: halt at end of memory ----------------
    initial begin
        rst_s = 1'b1;
        @(negedge CLK);
        check("small_reset_pc", s_pc, 32'd0);
        check("small_reset_valid", {31'd0, s_valid}, 32'd0);
        check("small_reset_halted", {31'd0, s_halted}, 32'd0);
        rst_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("small_seq_pc", s_pc, i);
            check("small_seq_valid", {31'd0, s_valid}, 32'd1);
        end
        repeat (3) begin
            @(negedge CLK);
            check("small_halt_pc", s_pc, 32'd3);
            check("small_halt_flag", {31'd0, s_halted}, 32'd1);
            check("small_halt_valid", {31'd0, s_valid}, 32'd0);
        end
        rst_s = 1'b1;
        @(negedge CLK);
        check("small_rst_pc", s_pc, 32'd0);
        check("small_rst_halted", {31'd0, s_halted}, 32'd0);
        check("small_rst_valid", {31'd0, s_valid}, 32'd0);
        check("small_rst_flush", {31'd0, s_flush}, 32'd0);
        rst_s = 1'b0;
        @(negedge CLK);
        check("small_rerun_pc", s_pc, 32'd0);
        check("small_rerun_valid", {31'd0, s_valid}, 32'd1);
        small_done = 1'b1;
    end

    // ---------------- main instance: directed then random ----------------
    initial begin
        RST = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
        br_target = 32'd0; jmp_target = 32'd0;
`ifdef FETCH_CTRL_EXC_EN
        exc = 1'b0;
`endif
        @(negedge CLK);
        check("boot_pc", newPC, 32'd0);
        check("boot_valid", {31'd0, fetch_valid}, 32'd0);
        check("boot_flush", {31'd0, flush}, 32'd0);
        check("boot_halted", {31'd0, halted}, 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle_pc", newPC, i);
            check("idle_valid", {31'd0, fetch_valid}, 32'd1);
        end

        // Branch taken at PC 3.
        do_reset();
        repeat (4) @(negedge CLK);
        check("pre_branch_pc", newPC, 32'd3);
        br_taken = 1'b1; br_target = 32'd40;
        @(negedge CLK);
        br_taken = 1'b0;
        check("branch_pc", newPC, 32'd40);
        check("branch_flush", {31'd0, flush}, 32'd1);
        check("branch_valid", {31'd0, fetch_valid}, 32'd1);
        @(negedge CLK);
        check("after_branch_pc", newPC, 32'd41);
        check("after_branch_flush", {31'd0, flush}, 32'd0);

        // Branch and jump together: branch wins.
        br_taken = 1'b1; br_target = 32'd8; jmp = 1'b1; jmp_target = 32'd20;
        @(negedge CLK);
        br_taken = 1'b0; jmp = 1'b0;
        check("br_over_jmp_pc", newPC, 32'd8);
        check("br_over_jmp_flush", {31'd0, flush}, 32'd1);

        // Three stall cycles at PC 5 with a jump in the second one.
        do_reset();
        repeat (6) @(negedge CLK);
        check("pre_stall_pc", newPC, 32'd5);
        stall = 1'b1;
        @(negedge CLK);
        check("stall_pc", newPC, 32'd5);
        check("stall_valid", {31'd0, fetch_valid}, 32'd0);
        jmp = 1'b1; jmp_target = 32'd12;
        @(negedge CLK);
        jmp = 1'b0;
        check("stall_jmp_pc", newPC, 32'd12);
        check("stall_jmp_flush", {31'd0, flush}, 32'd1);
        @(negedge CLK);
        stall = 1'b0;
        check("stall_hold_pc", newPC, 32'd12);
        check("stall_hold_valid", {31'd0, fetch_valid}, 32'd0);
        @(negedge CLK);
        check("resume_pc", newPC, 32'd12);
        check("resume_valid", {31'd0, fetch_valid}, 32'd1);
        @(negedge CLK);
        check("resume_next_pc", newPC, 32'd13);

        // Redirect outside memory halts with PC frozen; only reset leaves.
        br_taken = 1'b1; br_target = 32'd100;
        @(negedge CLK);
        br_taken = 1'b0;
        check("oob_halted", {31'd0, halted}, 32'd1);
        check("oob_pc", newPC, 32'd13);
        check("oob_valid", {31'd0, fetch_valid}, 32'd0);
        jmp = 1'b1; jmp_target = 32'd5;
        repeat (2) begin
            @(negedge CLK);
            check("halt_sticky", {31'd0, halted}, 32'd1);
            check("halt_pc_frozen", newPC, 32'd13);
        end
        jmp = 1'b0;
        do_reset();
        check("halt_reset_pc", newPC, 32'd0);
        check("halt_reset_halted", {31'd0, halted}, 32'd0);

        // Last legal word then sequential halt.
        @(negedge CLK);
        jmp = 1'b1; jmp_target = 32'd62;
        @(negedge CLK);
        jmp = 1'b0;
        check("edge_jmp_pc", newPC, 32'd62);
        @(negedge CLK);
        check("edge_last_pc", newPC, 32'd63);
        @(negedge CLK);
        check("edge_halt_pc", newPC, 32'd63);
        check("edge_halted", {31'd0, halted}, 32'd1);

`ifdef FETCH_CTRL_EXC_EN
        do_reset();
        repeat (8) @(negedge CLK);
        check("pre_exc_pc", newPC, 32'd7);
        exc = 1'b1; br_taken = 1'b1; br_target = 32'd30;
        @(negedge CLK);
        exc = 1'b0; br_taken = 1'b0;
        check("exc_pc", newPC, 32'd16);
        check("exc_epc", epc, 32'd7);
        check("exc_flush", {31'd0, flush}, 32'd1);
`endif

        // Randomized traffic checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            RST        = ($urandom_range(0, 39) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            jmp        = ($urandom_range(0, 7) == 0);
            br_target  = $urandom_range(0, 70);
            jmp_target = $urandom_range(0, 70);
`ifdef FETCH_CTRL_EXC_EN
            exc        = ($urandom_range(0, 15) == 0);
`endif
        end
        @(negedge CLK);
        RST = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
`ifdef FETCH_CTRL_EXC_EN
        exc = 1'b0;
`endif
        for (int k = 0; k < 1000 && !small_done; k++) @(negedge CLK);
        checks++;
        if (!small_done) begin
            errors++;
            $display("FAIL small_done: got 0, expected 1");
        end
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
